// File: rtl/pipe_stage_skid.sv
// Reusable pipeline-stage register with a 2-entry skid buffer; in_ready comes from held state and reset only. Latency is 1 falling edge.
// Backpressure: out_ready=0 holds the output beat and absorbs one more beat into skid before in_ready drops.
// Optional PIPE_STAGE_STATS_EN adds saturating stall_count/flush_count outputs.
module pipe_stage_skid #(
    parameter int CTRL_W = 8,
    parameter int DATA_W = 69,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  flush_count
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0]   main_data_q, main_data_d;
    logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0]   skid_data_q, skid_data_d;
    logic                accept;
    logic                deliver;

    assign occupancy = state_q;
    assign in_ready  = reset & (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign accept    = in_valid & in_ready;
    assign deliver   = out_valid & out_ready;
    // An empty main slot must never present a live control bit downstream.
    assign out_ctrl  = main_ctrl_q & {CTRL_W{out_valid}};
    assign out_data  = main_data_q;

    always_comb begin
        state_d     = state_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;
        if (flush) begin
            state_d     = EMPTY;
            main_ctrl_d = '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d     = ONE;
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
                    end
                end
                ONE: begin
                    if (accept && deliver) begin
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
                    end else if (accept) begin
                        state_d     = FULL;
                        skid_ctrl_d = in_ctrl;
                        skid_data_d = in_data;
                    end else if (deliver) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (deliver) begin
                        state_d     = ONE;
                        main_ctrl_d = skid_ctrl_q;
                        main_data_d = skid_data_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(negedge clock) begin
        if (!reset) begin
            state_q     <= EMPTY;
            main_ctrl_q <= '0;
            main_data_q <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
        end else begin
            state_q     <= state_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
        end
    end

`ifdef PIPE_STAGE_STATS_EN
    localparam logic [CNT_W+1:0] CNT_MAX = {2'b00, {CNT_W{1'b1}}};

    logic [CNT_W-1:0] stall_count_q;
    logic [CNT_W-1:0] flush_count_q;
    logic [CNT_W+1:0] flush_sum;

    // Two spare bits so the add cannot wrap before the saturation compare.
    assign flush_sum   = {2'b00, flush_count_q} + {{CNT_W{1'b0}}, occupancy};
    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;

    always_ff @(negedge clock) begin
        if (!reset) begin
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            if (out_valid && !out_ready && (stall_count_q != {CNT_W{1'b1}})) begin
                stall_count_q <= stall_count_q + 1'b1;
            end
            if (flush) begin
                flush_count_q <= (flush_sum > CNT_MAX) ? {CNT_W{1'b1}} : flush_sum[CNT_W-1:0];
            end
        end
    end
`else
    // Counter width is meaningful only when statistics are compiled in.
    if (CNT_W < 1 || CTRL_W < 1 || DATA_W < 1) begin : g_illegal_width
    end
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboarded bench for pipe_stage_skid: a FIFO-of-beats reference model with directed and random stimulus.
// Beats are pushed when the driver's handshake lands; a monitor pops them on delivery, a checker compares every cycle.
module tb_pipe_stage_skid;
    localparam int CW       = 8;
    localparam int DW       = 69;
    localparam int TB_CNT_W = 3;

    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } beat_t;

    logic          clock = 1'b0;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
    logic [1:0]    occupancy;
`ifdef PIPE_STAGE_STATS_EN
    logic [TB_CNT_W-1:0] stall_count;
    logic [TB_CNT_W-1:0] flush_count;
    int                  stall_m = 0;
    int                  flush_m = 0;
    localparam int       CNT_MAX = (1 << TB_CNT_W) - 1;
`endif

    beat_t         exp_q[$];
    logic [DW-1:0] last_head = '0;
    int            checks   = 0;
    int            failures = 0;

    always #5 clock = ~clock;

    pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(TB_CNT_W)) dut (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .occupancy (occupancy)
`ifdef PIPE_STAGE_STATS_EN
        ,
        .stall_count (stall_count),
        .flush_count (flush_count)
`endif
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One cycle: inputs change 1 after posedge, handshake decided before the falling edge.
    task automatic step(input logic iv, input logic [CW-1:0] c, input logic [DW-1:0] d,
                        input logic ordy, input logic fl, input logic rst_n);
        logic acc;
        @(posedge clock);
        #1;
        in_valid  = iv;
        in_ctrl   = c;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        reset     = rst_n;
        #2;
        acc = reset && !flush && in_valid && in_ready;
        #1;
        if (acc) exp_q.push_back('{c: c, d: d});
    endtask

    // Monitor: runs 3 after posedge, before the driver's push for the same edge.
    always @(posedge clock) begin
        int    occ_before;
        beat_t b;
        #3;
        occ_before = exp_q.size();
        if (reset && occ_before > 0 && out_ready) begin
            b = exp_q.pop_front();
            check("deliver_ctrl", 128'(out_ctrl), 128'(b.c));
            check("deliver_data", 128'(out_data), 128'(b.d));
        end
`ifdef PIPE_STAGE_STATS_EN
        if (reset && occ_before > 0 && !out_ready && stall_m < CNT_MAX) stall_m++;
        if (reset && flush) flush_m = (flush_m + occ_before > CNT_MAX) ? CNT_MAX : flush_m + occ_before;
        if (!reset) begin
            stall_m = 0;
            flush_m = 0;
        end
`endif
        if (!reset) begin
            exp_q.delete();
            last_head = '0;
        end else if (flush) begin
            exp_q.delete();
        end
    end

    always @(negedge clock) begin
        #2;
        if (exp_q.size() > 0) last_head = exp_q[0].d;
        check("occupancy", 128'(occupancy), 128'(exp_q.size()));
        check("out_valid", 128'(out_valid), 128'(exp_q.size() != 0));
        check("in_ready", 128'(in_ready), 128'(reset && exp_q.size() < 2));
        check("out_ctrl", 128'(out_ctrl), (exp_q.size() > 0) ? 128'(exp_q[0].c) : 128'(0));
        check("out_data", 128'(out_data), (exp_q.size() > 0) ? 128'(exp_q[0].d) : 128'(last_head));
`ifdef PIPE_STAGE_STATS_EN
        check("stall_count", 128'(stall_count), 128'(stall_m));
        check("flush_count", 128'(flush_count), 128'(flush_m));
`endif
    end

    initial begin
        logic [95:0] r;
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_ctrl = '0; in_data = '0;

        repeat (3) step(1'b1, 8'hff, 69'hff, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h05, 69'h1234, 1'b1, 1'b0, 1'b1);

        for (int i = 0; i < 10; i++) step(1'b1, 8'(i + 1), 69'(i), 1'b1, 1'b0, 1'b1);
        step(1'b0, 8'h00, 69'h0, 1'b1, 1'b0, 1'b1);

        step(1'b1, 8'h0a, 69'ha, 1'b1, 1'b0, 1'b1);
        step(1'b1, 8'h0b, 69'hb, 1'b0, 1'b0, 1'b1);
        repeat (2) step(1'b1, 8'h0c, 69'hc, 1'b0, 1'b0, 1'b1);
        repeat (2) step(1'b1, 8'h0c, 69'hc, 1'b1, 1'b0, 1'b1);
        step(1'b0, 8'h00, 69'h0, 1'b1, 1'b0, 1'b1);

        step(1'b1, 8'h0e, 69'he, 1'b0, 1'b0, 1'b1);
        step(1'b1, 8'h0f, 69'hf, 1'b0, 1'b0, 1'b1);
        step(1'b1, 8'h0d, 69'hd, 1'b0, 1'b1, 1'b1);
        step(1'b0, 8'h00, 69'h0, 1'b1, 1'b0, 1'b1);

        step(1'b1, 8'h11, 69'h11, 1'b1, 1'b0, 1'b1);
        step(1'b1, 8'h12, 69'h12, 1'b1, 1'b0, 1'b1);
        step(1'b1, 8'h13, 69'h13, 1'b1, 1'b1, 1'b1);
        step(1'b0, 8'h00, 69'h0, 1'b1, 1'b0, 1'b1);

        step(1'b1, 8'h21, 69'h21, 1'b1, 1'b0, 1'b1);
        repeat (5) step(1'b1, 8'h22, 69'h22, 1'b0, 1'b0, 1'b1);
        step(1'b0, 8'h00, 69'h0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 8'h00, 69'h0, 1'b1, 1'b0, 1'b1);

        for (int n = 0; n < 1500; n++) begin
            r = {$urandom(), $urandom(), $urandom()};
            step($urandom_range(0, 3) != 0, 8'($urandom()), r[DW-1:0],
                 $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0,
                 $urandom_range(0, 199) != 0);
        end
        step(1'b0, 8'h00, 69'h0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 8'h00, 69'h0, 1'b1, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
Parametrised pipeline-stage register that generalises the fixed EX/MEM latch into a reusable stage for any pipeline boundary. It carries a control word and a data word with a valid/ready handshake, stall (backpressure) and flush support. A 2-entry skid buffer lets `in_ready` be registered-state only, while still sustaining one beat per cycle. Control bits are forced to zero in every bubble, so no write or regWrite can fire from an empty slot.

Parameters:
- CTRL_W, 8, width of control word (regWrite, memToReg, memWrite, memReadWidth, etc.); zeroed on bubble.
- DATA_W, 69, width of data word (writeRegister, writeData, aluOut packed); never zeroed except on reset.
- CNT_W, 16, width of statistics counters (used only with the optional feature).

Ports:
- clock, input, 1, stage clock; all state updates on the falling edge.
- reset, input, 1, synchronous, active-low; sampled on the falling edge of clock.
- flush, input, 1, synchronous kill of all held beats and of the current input beat.
- in_valid, input, 1, upstream beat present.
- in_ready, output, 1, stage can accept a beat this cycle.
- in_ctrl, input, CTRL_W, upstream control word.
- in_data, input, DATA_W, upstream data word.
- out_valid, output, 1, output beat present.
- out_ready, input, 1, downstream accepts the beat (0 = stall).
- out_ctrl, output, CTRL_W, control word; all zeros whenever out_valid=0.
- out_data, output, DATA_W, data word; holds its last value when out_valid=0.
- occupancy, output, 2, number of held beats (0, 1 or 2).

Behaviour:
- Storage and handshake:
  - Storage is a main register (drives the outputs) plus a skid register.
  - accept = in_valid & in_ready.
  - deliver = out_valid & out_ready.
- Reset (reset=0 at a falling edge):
  - Both valid bits cleared; out_ctrl=0, out_data=0, occupancy=0.
  - in_ready is forced to 0 while reset=0, and equals 1 on the first cycle after release.
- in_ready:
  - Combinational from state only: in_ready = reset & (occupancy != 2).
  - It never depends on out_ready.
- State machine (state = occupancy), evaluated when flush=0:
  - EMPTY(0):
    - accept -> ONE; main <= in.
    - Otherwise stay.
  - ONE(1):
    - accept & deliver -> ONE; main <= in.
    - accept & !deliver -> FULL; skid <= in.
    - !accept & deliver -> EMPTY.
    - Neither -> stay.
  - FULL(2):
    - accept is impossible (in_ready=0).
    - deliver -> ONE; main <= skid.
    - Otherwise stay.
- Ordering and latency:
  - Strict FIFO order; no beat is ever duplicated or dropped except by flush.
  - Latency is 1 falling edge from accept to out_valid when the stage is EMPTY.
  - Sustained throughput is 1 beat per cycle while out_ready=1.
- Stall:
  - out_ready=0 holds out_ctrl and out_data stable while out_valid=1.
  - One further beat is absorbed into skid, then in_ready drops.
- Flush (flush=1 at a falling edge, reset=1):
  - occupancy <= 0; out_valid <= 0; out_ctrl <= 0.
  - Any beat presented that cycle is discarded even if in_valid & in_ready (upstream is flushed together).
  - A concurrent deliver still counts as delivered downstream.
  - in_ready is 1 on the next cycle.
- Priority: reset > flush > normal operation.
- Bubble rule: out_ctrl is driven from the registered main control field ANDed with main_valid. A cleared slot always shows zero control.
- Width rules:
  - in_ctrl and in_data are stored verbatim; no packing or interpretation inside the block.
  - CTRL_W >= 1 and DATA_W >= 1 are required.

Optional Feature:
- Macro: PIPE_STAGE_STATS_EN.
- When defined, the block adds these outputs:
  - stall_count[CNT_W]: increments on each cycle with out_valid & !out_ready.
  - flush_count[CNT_W]: increments by the occupancy value discarded on each flush edge.
- Counter rules:
  - Both counters saturate at all-ones and never wrap.
  - Both clear on reset only.
- When not defined: these ports and counters do not exist, and the block has identical handshake behaviour.

Test Plan:
- Reset and first beat: hold reset=0 for 3 cycles with in_valid=1 -> in_ready=0, out_valid=0, out_ctrl=0, out_data=0. Release reset, present ctrl=8'h05, data=69'h1234 -> out_valid=1 with those values one falling edge later.
- Streaming: out_ready=1, 10 back-to-back beats with data 0..9 -> out_data 0..9 on consecutive cycles, occupancy never exceeds 1, no bubbles.
- Stall: occupancy 1 with data=A; set out_ready=0 and offer B then C.
  - Expect: B is accepted, occupancy=2, in_ready=0, C is held off, out_data stays A.
  - Release out_ready: outputs A, B, C in order.
- Flush mid-stall: occupancy=2, flush=1 with in_valid=1 (data D) -> next cycle occupancy=0, out_valid=0, out_ctrl=0, D never appears at the output.
- Simultaneous events: occupancy=1, accept and deliver in the same cycle -> occupancy stays 1 and the new beat is on the output. The same condition with flush=1 -> occupancy 0.
- Stats (PIPE_STAGE_STATS_EN): 5 stall cycles, then a flush at occupancy=2 -> stall_count=5, flush_count=2. With CNT_W=2, 6 stall cycles -> stall_count=3 (saturated).
